// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
//   Sequential RV32I instruction encoder. It turns decoded operation requests
//   into 32-bit instruction words for the subset the control decoder accepts:
//   lw, sw, R-type, I-type ALU, beq and jal.
//
//   Pipeline:
//     Stage 1  registers an accepted request.
//     Stage 2  encodes the request and pushes the word into the output FIFO
//              in the same cycle.
//   A byte-address counter tracks the head word's instruction-memory address.
//   It advances by 4 on each output handshake.
//
//   Illegal requests take a stage-1 slot, push nothing and set the sticky err
//   flag. A request is illegal for kind 6/7, for an undefined ALU code
//   (R/I kinds), or for an I-type request with alu=sub.
//
//   Optional feature macro: ENC_RANGE_CHECK_EN
//     defined   : immediates that do not fit their field are treated as
//                 illegal, as are beq/jal offsets with bit 0 set.
//     undefined : immediates are silently truncated to the field width.
//
// Parameters
//   DEPTH      output FIFO entries (power of two, >= 2)
//   ADDR_W     width of out_addr
//   BASE_ADDR  first emitted byte address
//
// Ports
//   clk, rst_n             clock (rising edge), async active-low reset
//   in_valid / in_ready    request handshake
//   in_kind                0 lw, 1 sw, 2 R, 3 I, 4 beq, 5 jal (6/7 illegal)
//   in_alu                 000 add, 001 sub, 101 slt, 110 or, 010 and
//   in_rd/in_rs1/in_rs2    register indices
//   in_imm                 signed byte immediate / offset (21 bits)
//   out_valid / out_ready  word handshake
//   out_instr              FIFO head word (0 when empty)
//   out_addr               byte address of the head word
//   err                    sticky illegal-request flag
// -----------------------------------------------------------------------------
module instr_encoder #(
  parameter int                DEPTH     = 4,
  parameter int                ADDR_W    = 10,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_kind,
  input  logic [2:0]        in_alu,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [20:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 2;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

`ifdef ENC_RANGE_CHECK_EN
  localparam bit RANGE_CHECK = 1'b1;
`else
  localparam bit RANGE_CHECK = 1'b0;
`endif

  typedef enum logic [2:0] {
    K_LW  = 3'd0,
    K_SW  = 3'd1,
    K_R   = 3'd2,
    K_I   = 3'd3,
    K_BEQ = 3'd4,
    K_JAL = 3'd5
  } kind_e;

  typedef struct packed {
    logic [2:0]  kind;
    logic [2:0]  alu;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [20:0] imm;
  } req_t;

  // Stage 1 ------------------------------------------------------------------
  logic s1_valid;
  req_t s1_req;
  logic accept;

  // FIFO state ---------------------------------------------------------------
  logic [31:0]   mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic          push, pop;

  // Stage 2 encode results ---------------------------------------------------
  logic [31:0] enc_word;
  logic        enc_legal;

  // Stage 1 counts against capacity. Every accepted request is then
  // guaranteed a FIFO slot one cycle later, so stage 2 never has to stall.
  assign in_ready  = (count + CW'(s1_valid)) < DEPTH_C;
  assign accept    = in_valid & in_ready;
  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;
  assign push      = s1_valid & enc_legal;
  assign out_instr = out_valid ? mem[rd_ptr] : '0;

  // NOTE: sequential state uses non-blocking assignments so that every
  // register samples values from before the edge, whatever the order of
  // the statements.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_req   <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_req <= '{kind: in_kind, alu: in_alu, rd: in_rd, rs1: in_rs1,
                    rs2: in_rs2, imm: in_imm};
      end
    end
  end

  // Stage 2: encode
  always_comb begin
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        alu_ok;
    logic        range_ok;
    logic [20:0] imm;
    // NOTE: every variable gets a default before any branch. A path that
    // leaves a variable unassigned would infer a latch.
    imm      = s1_req.imm;
    f3       = 3'b000;
    f7       = 7'b0000000;
    alu_ok   = 1'b1;
    range_ok = 1'b1;
    enc_word = '0;
    enc_legal = 1'b1;

    unique case (s1_req.alu)
      3'b000:  f3 = 3'b000;
      3'b001:  begin f3 = 3'b000; f7 = 7'b0100000; end
      3'b101:  f3 = 3'b010;
      3'b110:  f3 = 3'b110;
      3'b010:  f3 = 3'b111;
      default: alu_ok = 1'b0;
    endcase

    case (kind_e'(s1_req.kind))
      K_LW: begin
        enc_word = {imm[11:0], s1_req.rs1, 3'b010, s1_req.rd, 7'b0000011};
        range_ok = (&imm[20:11]) | ~(|imm[20:11]);
      end
      K_SW: begin
        enc_word = {imm[11:5], s1_req.rs2, s1_req.rs1, 3'b010, imm[4:0],
                    7'b0100011};
        range_ok = (&imm[20:11]) | ~(|imm[20:11]);
      end
      K_R: begin
        enc_word  = {f7, s1_req.rs2, s1_req.rs1, f3, s1_req.rd, 7'b0110011};
        enc_legal = alu_ok;
      end
      K_I: begin
        // I-type has no subtract: addi with a negated immediate covers it.
        enc_word  = {imm[11:0], s1_req.rs1, f3, s1_req.rd, 7'b0010011};
        enc_legal = alu_ok & (s1_req.alu != 3'b001);
        range_ok  = (&imm[20:11]) | ~(|imm[20:11]);
      end
      K_BEQ: begin
        enc_word = {imm[12], imm[10:5], s1_req.rs2, s1_req.rs1, 3'b000,
                    imm[4:1], imm[11], 7'b1100011};
        range_ok = ((&imm[20:12]) | ~(|imm[20:12])) & ~imm[0];
      end
      K_JAL: begin
        enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], s1_req.rd,
                    7'b1101111};
        range_ok = ~imm[0];
      end
      default: enc_legal = 1'b0;
    endcase

    if (RANGE_CHECK && !range_ok) begin
      enc_legal = 1'b0;
    end
  end

  // Sticky error, FIFO pointers/count and address counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err      <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      out_addr <= BASE_ADDR;
    end else begin
      if (s1_valid && !enc_legal) begin
        err <= 1'b1;
      end
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr   <= rd_ptr + PW'(1);
        out_addr <= out_addr + ADDR_W'(4);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  // NOTE: the storage array has no reset. Entries are only readable once
  // written, and out_instr is forced to 0 while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= enc_word;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// -----------------------------------------------------------------------------
// tb_instr_encoder
//   Directed self-checking bench for instr_encoder (default parameters).
//   Inputs change on the falling edge and outputs are sampled there too, so
//   the DUT sees stable inputs at every rising edge.
// -----------------------------------------------------------------------------
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_kind = '0;
  logic [2:0]  in_alu = '0;
  logic [4:0]  in_rd = '0;
  logic [4:0]  in_rs1 = '0;
  logic [4:0]  in_rs2 = '0;
  logic [20:0] in_imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [9:0]  out_addr;
  logic        err;

  int checks = 0;
  int errors = 0;

  instr_encoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_kind   (in_kind),
    .in_alu    (in_alu),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_addr  (out_addr),
    .err       (err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Asserts reset between falling edges and checks the asynchronous clear.
  task automatic do_reset();
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_instr", out_instr, 0);
    check("rst_out_addr",  out_addr,  0);
    check("rst_err",       err,       0);
    check("rst_in_ready",  in_ready,  1);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Called on a falling edge. Returns on the falling edge right after the
  // rising edge that accepted the request, with in_valid dropped.
  task automatic put(input logic [2:0] k, input logic [2:0] a,
                     input logic [4:0] rd, input logic [4:0] rs1,
                     input logic [4:0] rs2, input logic [20:0] imm);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_kind  = k;
    in_alu   = a;
    in_rd    = rd;
    in_rs1   = rs1;
    in_rs2   = rs2;
    in_imm   = imm;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n == 50) check("put_timeout_in_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Checks the head word and pops it with a one-cycle out_ready pulse.
  task automatic pop_check(input string tag, input logic [31:0] exp_instr,
                           input logic [31:0] exp_addr);
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_instr"}, out_instr, exp_instr);
    check({tag, "_addr"},  out_addr,  exp_addr);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    // ---- Reset and a single addi x1,x0,5 -----------------------------------
    do_reset();
    put(3'd3, 3'b000, 5'd1, 5'd0, 5'd0, 21'd5);
    check("addi_latency_not_yet", out_valid, 0);
    @(negedge clk);
    check("addi_latency_valid", out_valid, 1);
    check("addi_instr", out_instr, 32'h0050_0093);
    check("addi_addr",  out_addr,  32'h000);
    @(negedge clk);
    check("addi_hold_instr", out_instr, 32'h0050_0093);
    pop_check("addi_pop", 32'h0050_0093, 32'h000);
    check("addi_empty", out_valid, 0);
    check("addi_addr_next", out_addr, 32'h004);

    // ---- Back-to-back add/sub with out_ready held high ---------------------
    do_reset();
    out_ready = 1'b1;
    put(3'd2, 3'b000, 5'd3, 5'd1, 5'd2, 21'd0);
    check("b2b_stage1_only", out_valid, 0);
    put(3'd2, 3'b001, 5'd3, 5'd1, 5'd2, 21'd0);
    check("b2b_add_instr", out_instr, 32'h0020_81B3);
    check("b2b_add_addr",  out_addr,  32'h000);
    @(negedge clk);
    check("b2b_sub_valid", out_valid, 1);
    check("b2b_sub_instr", out_instr, 32'h4020_81B3);
    check("b2b_sub_addr",  out_addr,  32'h004);
    @(negedge clk);
    check("b2b_drained", out_valid, 0);
    check("b2b_addr_end", out_addr, 32'h008);
    out_ready = 1'b0;

    // ---- lw / sw / beq / jal -----------------------------------------------
    do_reset();
    put(3'd0, 3'b000, 5'd5, 5'd2, 5'd0, 21'd8);
    put(3'd1, 3'b000, 5'd0, 5'd2, 5'd5, 21'd12);
    put(3'd4, 3'b000, 5'd0, 5'd1, 5'd2, 21'h1F_FFFC);
    put(3'd5, 3'b000, 5'd1, 5'd0, 5'd0, 21'd8);
    pop_check("lw",  32'h0081_2283, 32'h000);
    pop_check("sw",  32'h0051_2623, 32'h004);
    pop_check("beq", 32'hFE20_8EE3, 32'h008);
    pop_check("jal", 32'h0080_00EF, 32'h00C);
    check("mem_ops_empty", out_valid, 0);

    // ---- Backpressure: six requests with out_ready low ---------------------
    do_reset();
    put(3'd3, 3'b000, 5'd1, 5'd0, 5'd0, 21'd1);
    put(3'd3, 3'b000, 5'd1, 5'd0, 5'd0, 21'd2);
    put(3'd3, 3'b000, 5'd1, 5'd0, 5'd0, 21'd3);
    put(3'd3, 3'b000, 5'd1, 5'd0, 5'd0, 21'd4);
    check("full_in_ready", in_ready, 0);
    check("full_head", out_instr, 32'h0010_0093);
    in_valid = 1'b1;
    in_kind  = 3'd3;
    in_alu   = 3'b000;
    in_rd    = 5'd1;
    in_rs1   = 5'd0;
    in_rs2   = 5'd0;
    in_imm   = 21'd5;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("full_hold_ready", in_ready, 0);
      check("full_hold_head", out_instr, 32'h0010_0093);
      check("full_hold_addr", out_addr, 32'h000);
    end
    in_valid = 1'b0;
    pop_check("bp_w1", 32'h0010_0093, 32'h000);
    put(3'd3, 3'b000, 5'd1, 5'd0, 5'd0, 21'd5);
    check("refill_in_ready", in_ready, 0);
    pop_check("bp_w2", 32'h0020_0093, 32'h004);
    put(3'd3, 3'b000, 5'd1, 5'd0, 5'd0, 21'd6);
    pop_check("bp_w3", 32'h0030_0093, 32'h008);
    pop_check("bp_w4", 32'h0040_0093, 32'h00C);
    pop_check("bp_w5", 32'h0050_0093, 32'h010);
    pop_check("bp_w6", 32'h0060_0093, 32'h014);
    check("bp_empty", out_valid, 0);
    check("bp_ready_again", in_ready, 1);

    // ---- Illegal requests, then addi ---------------------------------------
    do_reset();
    put(3'd6, 3'b000, 5'd1, 5'd0, 5'd0, 21'd0);   // illegal kind
    put(3'd3, 3'b001, 5'd1, 5'd0, 5'd0, 21'd0);   // I-type sub
    put(3'd2, 3'b011, 5'd1, 5'd0, 5'd0, 21'd0);   // undefined alu code
    put(3'd3, 3'b000, 5'd1, 5'd0, 5'd0, 21'd5);
    check("illegal_err_set", err, 1);
    check("illegal_nothing_queued", out_valid, 0);
    @(negedge clk);
    pop_check("illegal_then_addi", 32'h0050_0093, 32'h000);
    check("illegal_only_one", out_valid, 0);
    repeat (3) @(negedge clk);
    check("illegal_err_sticky", err, 1);

    // ---- addi with imm=2048 (out of 12-bit range) --------------------------
    do_reset();
    put(3'd3, 3'b000, 5'd1, 5'd0, 5'd0, 21'd2048);
    @(negedge clk);
`ifdef ENC_RANGE_CHECK_EN
    check("range_dropped", out_valid, 0);
    check("range_err", err, 1);
`else
    check("range_err_clear", err, 0);
    pop_check("range_truncated", 32'h8000_0093, 32'h000);
`endif

    // ---- Reset mid-stream --------------------------------------------------
    do_reset();
    put(3'd3, 3'b000, 5'd1, 5'd0, 5'd0, 21'd1);
    put(3'd3, 3'b000, 5'd1, 5'd0, 5'd0, 21'd2);
    pop_check("pre_reset", 32'h0010_0093, 32'h000);
    do_reset();
    put(3'd3, 3'b000, 5'd1, 5'd0, 5'd0, 21'd3);
    @(negedge clk);
    pop_check("post_reset", 32'h0030_0093, 32'h000);
    check("post_reset_empty", out_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
